// File: rtl/pipelined_adder.sv
// pipelined_adder: add/subtract split into STAGES carry-chain chunks, valid/ready handshake, carry/overflow/zero flags
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAGW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             sub,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [TAGW-1:0]  out_tag,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);
  localparam int CW = WIDTH / STAGES;
  logic adv;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  // Each stage carries full-width operands and partial result; the last stage is the output register.
  for (genvar g = 0; g < STAGES; g++) begin : st
    logic [WIDTH-1:0] ia, ib, ir, nr, ra, rb, rr;
    logic [TAGW-1:0]  it, rt;
    logic             ic, iv, rv, rc, ro, rz;
    logic [CW:0]      cs;
    if (g == 0) begin : src
      assign ia = data1;
      assign ib = sub ? ~data2 : data2;
      assign ir = '0;
      assign ic = sub;
      assign iv = in_valid;
      assign it = in_tag;
    end else begin : src
      assign ia = st[g-1].ra;
      assign ib = st[g-1].rb;
      assign ir = st[g-1].rr;
      assign ic = st[g-1].rc;
      assign iv = st[g-1].rv;
      assign it = st[g-1].rt;
    end
    assign cs = {1'b0, ia[g*CW +: CW]} + {1'b0, ib[g*CW +: CW]} + (CW+1)'(ic);
    always_comb begin
      nr = ir;
      nr[g*CW +: CW] = cs[CW-1:0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rv <= 1'b0;
        ra <= '0;
        rb <= '0;
        rr <= '0;
        rt <= '0;
        rc <= 1'b0;
        ro <= 1'b0;
        rz <= 1'b0;
      end else if (adv) begin
        rv <= iv;
        if (iv) begin
          ra <= ia;
          rb <= ib;
          rr <= nr;
          rt <= it;
          rc <= cs[CW];
          ro <= ia[WIDTH-1] ^ ib[WIDTH-1] ^ nr[WIDTH-1] ^ cs[CW];
          rz <= nr == '0;
        end
      end
    end
  end
  assign out_valid = st[STAGES-1].rv;
  assign out       = st[STAGES-1].rr;
  assign out_tag   = st[STAGES-1].rt;
  assign carry     = st[STAGES-1].rc;
  assign overflow  = st[STAGES-1].ro;
  assign zero      = st[STAGES-1].rz;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed table plus handshake/stall/reset sequences on 32x2, 32x1 and 64x4 instances
module tb_pipelined_adder;
  typedef struct packed {
    logic [63:0] o;
    logic [3:0]  t;
    logic        c, v, z;
  } res_t;
  typedef struct {
    logic [31:0] a, b;
    logic        s;
    logic [31:0] o;
    logic        c, v, z;
  } vec_t;
  logic clk = 0, rst_n = 1, in_valid = 0, sub = 0, or2 = 1;
  logic [31:0] data1 = 0, data2 = 0;
  logic [63:0] da = 0, db = 0;
  logic [3:0] in_tag = 0;
  logic ir1, ir2, ir4, ov1, ov2, ov4, c1, c2, c4, v1, v2, v4, z1, z2, z4;
  logic [31:0] o1, o2;
  logic [63:0] o4;
  logic [3:0] t1, t2, t4;
  int checks = 0, errors = 0;
  vec_t vecs[9];
  res_t q[$];
  res_t sv, e;
  logic stall = 0;
  int sent = 0, cyc = 0, spur = 0;
  always #5 clk = ~clk;
  pipelined_adder #(.WIDTH(32), .STAGES(2), .TAGW(4)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(ir2), .data1(data1), .data2(data2), .sub(sub), .in_tag(in_tag), .out_valid(ov2), .out_ready(or2),
    .out(o2), .out_tag(t2), .carry(c2), .overflow(v2), .zero(z2));
  pipelined_adder #(.WIDTH(32), .STAGES(1), .TAGW(4)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(ir1), .data1(data1), .data2(data2), .sub(sub), .in_tag(in_tag), .out_valid(ov1), .out_ready(1'b1),
    .out(o1), .out_tag(t1), .carry(c1), .overflow(v1), .zero(z1));
  pipelined_adder #(.WIDTH(64), .STAGES(4), .TAGW(4)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(ir4), .data1(da), .data2(db), .sub(sub), .in_tag(in_tag), .out_valid(ov4), .out_ready(1'b1),
    .out(o4), .out_tag(t4), .carry(c4), .overflow(v4), .zero(z4));
  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  function automatic res_t pk(input logic [63:0] o, input logic [3:0] t, input logic c, input logic v, input logic z);
    pk.o = o;
    pk.t = t;
    pk.c = c;
    pk.v = v;
    pk.z = z;
  endfunction
  function automatic res_t m32(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [3:0] t);
    logic [31:0] bb;
    logic [32:0] r;
    bb = s ? ~b : b;
    r = {1'b0, a} + {1'b0, bb} + 33'(s);
    m32 = pk({32'b0, r[31:0]}, t, r[32], (a[31] == bb[31]) && (r[31] != a[31]), r[31:0] == 32'b0);
  endfunction
  function automatic res_t m64(input logic [63:0] a, input logic [63:0] b, input logic s, input logic [3:0] t);
    logic [63:0] bb;
    logic [64:0] r;
    bb = s ? ~b : b;
    r = {1'b0, a} + {1'b0, bb} + 65'(s);
    m64 = pk(r[63:0], t, r[64], (a[63] == bb[63]) && (r[63] != a[63]), r[63:0] == 64'b0);
  endfunction
  // One isolated op into all three instances; checks value and accept-to-valid latency of each.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [3:0] t, input res_t e32);
    res_t e64;
    int l1 = 0, l2 = 0, l4 = 0;
    e64 = m64({~a, a}, {b, b}, s, t);
    @(negedge clk);
    data1 = a; data2 = b; da = {~a, a}; db = {b, b}; sub = s; in_tag = t; in_valid = 1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1;
      in_valid = 0;
      if (ov1 && l1 == 0) begin
        l1 = n;
        chk("s1 result", pk({32'b0, o1}, t1, c1, v1, z1), e32);
      end
      if (ov2 && l2 == 0) begin
        l2 = n;
        chk("s2 result", pk({32'b0, o2}, t2, c2, v2, z2), e32);
      end
      if (ov4 && l4 == 0) begin
        l4 = n;
        chk("w64 result", pk(o4, t4, c4, v4, z4), e64);
      end
    end
    chk("s1 latency", l1, 1);
    chk("s2 latency", l2, 2);
    chk("w64 latency", l4, 4);
  endtask
  initial begin
    vecs[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h00000007, 32'h00000007, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0};
    #1 rst_n = 0;
    #2;
    chk("reset state", {ir2, ov2, pk({32'b0, o2}, t2, c2, v2, z2)}, {1'b1, 1'b0, 71'b0});
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, 4'(i), pk({32'b0, vecs[i].o}, 4'(i), vecs[i].c, vecs[i].v, vecs[i].z));
    // Random stream with random backpressure on the 32x2 instance, scoreboarded in order.
    while ((sent < 100 || q.size() != 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      in_valid = sent < 100 && $urandom_range(3) != 0;
      data1 = $urandom; data2 = $urandom; sub = 1'($urandom_range(1)); in_tag = sent[3:0];
      or2 = 1'($urandom_range(1));
      #1;
      if (stall) chk("stall hold", {ov2, pk({32'b0, o2}, t2, c2, v2, z2)}, {1'b1, sv});
      if (ov2 && or2) begin
        if (q.size() == 0) chk("duplicate output", 1, 0);
        else begin
          e = q.pop_front();
          chk("stream result", pk({32'b0, o2}, t2, c2, v2, z2), e);
        end
      end
      if (in_valid && ir2) begin
        q.push_back(m32(data1, data2, sub, in_tag));
        sent++;
      end
      stall = ov2 && !or2;
      sv = pk({32'b0, o2}, t2, c2, v2, z2);
    end
    chk("stream complete", {sent, q.size()}, {32'd100, 32'd0});
    @(negedge clk);
    in_valid = 0; or2 = 1;
    repeat (6) @(negedge clk);
    // Two ops in flight, then async reset mid-cycle.
    data1 = 1; data2 = 2; da = 1; db = 2; sub = 0; in_valid = 1;
    @(negedge clk);
    data1 = 3; data2 = 4;
    @(negedge clk);
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("async reset", {ir2, ov1, ov2, ov4, pk({32'b0, o2}, t2, c2, v2, z2)}, {1'b1, 1'b0, 1'b0, 1'b0, 71'b0});
    @(negedge clk);
    rst_n = 1;
    repeat (6) begin
      @(negedge clk);
      if (ov1 || ov2 || ov4) spur++;
    end
    chk("no output after reset", spur, 0);
    run_op(32'hDEADBEEF, 32'h21524111, 1'b0, 4'hA, pk(64'h0000_0000_0000_0000, 4'hA, 1'b1, 1'b0, 1'b1));
    run_op(32'h00000010, 32'h00000020, 1'b1, 4'h5, pk(64'h0000_0000_FFFF_FFF0, 4'h5, 1'b0, 1'b0, 1'b0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
